// File: rtl/inst_decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, funct constants, type codes,
// skid-buffer states and the buffered entry layout.
package inst_decode_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_STORE_MAX = 3'b010;

  typedef enum logic [2:0] {
    TYPE_R    = 3'd0,
    TYPE_I    = 3'd1,
    TYPE_S    = 3'd2,
    TYPE_B    = 3'd3,
    TYPE_U    = 3'd4,
    TYPE_J    = 3'd5,
    TYPE_NONE = 3'd7
  } inst_type_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    inst_type_e  typ;
    logic [31:0] imm;
    logic        illegal;
  } dec_entry_t;

endpackage

// File: rtl/inst_decode_stage_imm_gen.sv
// Combinational RV32I classifier: instruction type, sign-extended immediate
// and illegal-encoding flag. Illegal words report TYPE_NONE with a zero imm.
module rv32_imm_gen
  import inst_decode_stage_pkg::*;
(
  input  logic [31:0] inst_code,
  output inst_type_e  inst_type,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  inst_type_e typ_raw;
  logic       bad;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = inst_code[6:0];
  assign f3  = inst_code[14:12];
  assign f7  = inst_code[31:25];

  assign imm_i = {{20{inst_code[31]}}, inst_code[31:20]};
  assign imm_s = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
  assign imm_b = {{19{inst_code[31]}}, inst_code[31], inst_code[7],
                  inst_code[30:25], inst_code[11:8], 1'b0};
  assign imm_u = {inst_code[31:12], 12'b0};
  assign imm_j = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12],
                  inst_code[20], inst_code[30:21], 1'b0};

  // Classify the opcode and flag funct3/funct7 combinations outside RV32I.
  always_comb begin
    typ_raw = TYPE_NONE;
    bad     = 1'b0;
    case (opc)
      OPC_OP: begin
        typ_raw = TYPE_R;
        bad = !((f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))));
      end
      OPC_OP_IMM: begin
        typ_raw = TYPE_I;
        if (f3 == F3_SLL)
          bad = (f7 != F7_BASE);
        else if (f3 == F3_SRL_SRA)
          bad = !((f7 == F7_BASE) || (f7 == F7_ALT));
      end
      OPC_LOAD: begin
        typ_raw = TYPE_I;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_JALR: begin
        typ_raw = TYPE_I;
        bad = (f3 != F3_JALR);
      end
      OPC_STORE: begin
        typ_raw = TYPE_S;
        bad = (f3 > F3_STORE_MAX);
      end
      OPC_BRANCH: begin
        typ_raw = TYPE_B;
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LUI, OPC_AUIPC: typ_raw = TYPE_U;
      OPC_JAL:            typ_raw = TYPE_J;
      default:            bad = 1'b1;
    endcase
  end

  assign illegal   = bad;
  assign inst_type = bad ? TYPE_NONE : typ_raw;

  // Select the immediate for the final type; R and NONE carry zero.
  always_comb begin
    imm = '0;
    case (inst_type)
      TYPE_I:  imm = imm_i;
      TYPE_S:  imm = imm_s;
      TYPE_B:  imm = imm_b;
      TYPE_U:  imm = imm_u;
      TYPE_J:  imm = imm_j;
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// RV32I decode stage: classifies incoming words, holds them in a 2-entry
// skid buffer (main + skid) with valid/ready on both sides, counts handouts.
module inst_decode_stage
  import inst_decode_stage_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ILL_W = 8
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_code,
  input  logic [31:0]      inst_add,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [2:0]       inst_type,
  output logic [31:0]      imm,
  output logic             illegal,
  output logic [CNT_W-1:0] decode_cnt,
  output logic [ILL_W-1:0] illegal_cnt
);

  function automatic logic [ILL_W-1:0] sat_inc(input logic [ILL_W-1:0] v);
    return (&v) ? v : v + ILL_W'(1);
  endfunction

  buf_state_e state_q, state_d;
  dec_entry_t ent_in, ent_p0, ent_p1, ent_out;
  inst_type_e in_type;
  logic [31:0] in_imm;
  logic        in_illegal;
  logic        in_ready_q, vld_p0, accept, take;
  logic        ld_main, ld_skid, mv_skid;

  rv32_imm_gen u_imm_gen (
    .inst_code (inst_code),
    .inst_type (in_type),
    .imm       (in_imm),
    .illegal   (in_illegal)
  );

  // Pack the freshly decoded word into a buffer entry.
  always_comb begin
    ent_in         = '0;
    ent_in.pc      = inst_add;
    ent_in.inst    = inst_code;
    ent_in.typ     = in_type;
    ent_in.imm     = in_imm;
    ent_in.illegal = in_illegal;
  end

  // A word offered during flush is dropped, so it never counts as accepted.
  assign vld_p0 = (state_q != BUF_EMPTY);
  assign accept = in_valid & in_ready_q & ~flush;
  assign take   = vld_p0 & out_ready;

  // Skid-buffer next state and entry load/move strobes.
  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          state_d = BUF_ONE;
          ld_main = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && take) begin
          ld_main = 1'b1;
        end else if (accept) begin
          state_d = BUF_TWO;
          ld_skid = 1'b1;
        end else if (take) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (take) begin
          state_d = BUF_ONE;
          mv_skid = 1'b1;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    if (flush) state_d = BUF_EMPTY;
  end

  // Buffer occupancy and registered ready; ready stays low during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != BUF_TWO);
    end
  end

  // ---- stage p0 (main entry) / p1 (skid entry) ----
  // Entry storage; only loaded under the strobes, not reset.
  always_ff @(posedge clk) begin
    if (ld_main)      ent_p0 <= ent_in;
    else if (mv_skid) ent_p0 <= ent_p1;
    if (ld_skid)      ent_p1 <= ent_in;
  end

  // Handout counters: decode count wraps, illegal count saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      decode_cnt  <= '0;
      illegal_cnt <= '0;
    end else if (take) begin
      decode_cnt <= decode_cnt + CNT_W'(1);
      if (ent_p0.illegal) illegal_cnt <= sat_inc(illegal_cnt);
    end
  end

  // Data outputs read zero whenever no entry is presented.
  assign ent_out   = vld_p0 ? ent_p0 : '0;
  assign out_valid = vld_p0;
  assign in_ready  = in_ready_q;
  assign out_pc    = ent_out.pc;
  assign opcode    = ent_out.inst[6:0];
  assign rd        = ent_out.inst[11:7];
  assign funct3    = ent_out.inst[14:12];
  assign rs1       = ent_out.inst[19:15];
  assign rs2       = ent_out.inst[24:20];
  assign funct7    = ent_out.inst[31:25];
  assign inst_type = ent_out.typ;
  assign imm       = ent_out.imm;
  assign illegal   = ent_out.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Scoreboard bench for inst_decode_stage: directed spec cases plus random
// traffic checked against a behavioural RV32I decode model.
module tb_inst_decode_stage;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst_code, inst_add, out_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, inst_type;
  logic        illegal;
  logic [15:0] decode_cnt;
  logic [7:0]  illegal_cnt;

  inst_decode_stage #(.CNT_W(16), .ILL_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_code(inst_code), .inst_add(inst_add),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .inst_type(inst_type),
    .imm(imm), .illegal(illegal),
    .decode_cnt(decode_cnt), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  typ;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] m_dec = '0;
  logic [7:0]  m_ill = '0;
  logic        rst_last = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [6:0] opc,
                              input logic [4:0] rdv, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [2:0] typ,
                              input logic [31:0] immv, input logic ill);
    exp_t e;
    e.pc = pc; e.opc = opc; e.rd = rdv; e.rs1 = r1; e.rs2 = r2;
    e.f3 = f3; e.f7 = f7; e.typ = typ; e.imm = immv; e.ill = ill;
    return e;
  endfunction

  // Reference decode: legality from the RV32I rule list, immediates by arithmetic shifts.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic signed [31:0] sw;
    logic [2:0] f3;
    logic [6:0] f7;
    logic legal;
    sw = $signed(w);
    f3 = w[14:12];
    f7 = w[31:25];
    e = mk(pc, w[6:0], w[11:7], w[19:15], w[24:20], f3, f7, 3'd7, 32'd0, 1'b0);
    legal = 1'b1;
    case (w[6:0])
      7'b0110011: begin e.typ = 3'd0; legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); end
      7'b0010011: begin e.typ = 3'd1; legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1; end
      7'b0000011: begin e.typ = 3'd1; legal = !(f3 == 3 || f3 == 6 || f3 == 7); end
      7'b1100111: begin e.typ = 3'd1; legal = (f3 == 0); end
      7'b0100011: begin e.typ = 3'd2; legal = (f3 <= 2); end
      7'b1100011: begin e.typ = 3'd3; legal = !(f3 == 2 || f3 == 3); end
      7'b0110111, 7'b0010111: e.typ = 3'd4;
      7'b1101111: e.typ = 3'd5;
      default: legal = 1'b0;
    endcase
    case (e.typ)
      3'd1: e.imm = 32'(sw >>> 20);
      3'd2: e.imm = 32'((sw >>> 25) <<< 5) | 32'(w[11:7]);
      3'd3: e.imm = 32'((sw >>> 31) <<< 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      3'd4: e.imm = w & 32'hFFFFF000;
      3'd5: e.imm = 32'((sw >>> 31) <<< 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: e.imm = 32'd0;
    endcase
    if (!legal) begin
      e.typ = 3'd7;
      e.imm = 32'd0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Drive one cycle of inputs; push the expected entry if the word is accepted.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic fl, input logic ordy, input logic use_exp,
                      input exp_t e, output logic acc);
    in_valid = v; inst_code = w; inst_add = pc; flush = fl; out_ready = ordy;
    @(negedge clk); #1;
    acc = v && in_ready && !fl && !reset;
    if (acc) q.push_back(use_exp ? e : ref_decode(w, pc));
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] pc, input logic use_exp,
                      input exp_t e, input logic ordy);
    logic acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      step(1'b1, w, pc, 1'b0, ordy, use_exp, e, acc);
      n++;
    end
    chk("send_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, ordy, 1'b0, '0, acc);
  endtask

  function automatic logic [31:0] gen_word();
    logic [6:0] opcs [9];
    logic [31:0] r;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    r = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      r[6:0] = opcs[$urandom_range(0, 8)];
      if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end
    return r;
  endfunction

  // Monitor: pops and compares on every out handshake, tracks counters and flow control.
  exp_t mon_e;
  logic mon_take, mon_ill;
  always @(negedge clk) begin
    chk("decode_cnt", 64'(decode_cnt), 64'(m_dec));
    chk("illegal_cnt", 64'(illegal_cnt), 64'(m_ill));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), rst_last ? 64'd0 : 64'(q.size() < 2));
    mon_take = out_valid && out_ready;
    mon_ill  = illegal;
    if (mon_take && q.size() == 0) begin
      chk("unexpected_output", 64'(out_valid), 64'd0);
    end else if (mon_take) begin
      mon_e = q.pop_front();
      mon_ill = mon_e.ill;
      chk("out_pc", 64'(out_pc), 64'(mon_e.pc));
      chk("fields", 64'({opcode, rd, rs1, rs2, funct3, funct7}),
          64'({mon_e.opc, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.f3, mon_e.f7}));
      chk("inst_type", 64'(inst_type), 64'(mon_e.typ));
      chk("imm", 64'(imm), 64'(mon_e.imm));
      chk("illegal", 64'(illegal), 64'(mon_e.ill));
    end
    if (reset) begin
      q.delete();
      m_dec = '0;
      m_ill = '0;
      rst_last = 1'b1;
    end else begin
      rst_last = 1'b0;
      if (mon_take) begin
        m_dec = m_dec + 16'd1;
        if (mon_ill && m_ill != 8'hFF) m_ill = m_ill + 8'd1;
      end
      if (flush) q.delete();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [15:0] cnt0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst_code = '0; inst_add = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({out_valid, in_ready, decode_cnt, illegal_cnt}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Two R-type words.
    send(32'h00940333, 32'h100, 1'b1, mk(32'h100, 7'h33, 5'd6, 5'd8, 5'd9, 3'd0, 7'h00, 3'd0, 32'd0, 1'b0), 1'b1);
    send(32'h413903b3, 32'h104, 1'b1, mk(32'h104, 7'h33, 5'd7, 5'd18, 5'd19, 3'd0, 7'h20, 3'd0, 32'd0, 1'b0), 1'b1);
    idle(3, 1'b1);
    chk("decode_cnt_two", 64'(decode_cnt), 64'd2);

    // addi, lui, jal.
    send(32'hFFF40293, 32'h200, 1'b1, mk(32'h200, 7'h13, 5'd5, 5'd8, 5'd31, 3'd0, 7'h7F, 3'd1, 32'hFFFFFFFF, 1'b0), 1'b1);
    send(32'h123453B7, 32'h204, 1'b1, mk(32'h204, 7'h37, 5'd7, 5'd8, 5'd3, 3'd5, 7'h09, 3'd4, 32'h12345000, 1'b0), 1'b1);
    send(32'hFFDFF3EF, 32'hABCD0008, 1'b1, mk(32'hABCD0008, 7'h6F, 5'd7, 5'd31, 5'd29, 3'd7, 7'h7F, 3'd5, 32'hFFFFFFFC, 1'b0), 1'b1);
    idle(3, 1'b1);

    // Back-pressure: three words with out_ready low.
    cnt0 = decode_cnt;
    send(32'h00A00093, 32'h300, 1'b0, '0, 1'b0);
    send(32'h00B00113, 32'h304, 1'b0, '0, 1'b0);
    chk("in_ready_full", 64'(in_ready), 64'd0);
    step(1'b1, 32'h00C00193, 32'h308, 1'b0, 1'b0, 1'b0, '0, acc);
    chk("no_accept_when_full", 64'(acc), 64'd0);
    send(32'h00C00193, 32'h308, 1'b0, '0, 1'b1);
    idle(4, 1'b1);
    chk("backpressure_none_lost", 64'(decode_cnt), 64'(cnt0 + 16'd3));

    // Illegal words and saturation, counted from a fresh reset.
    reset = 1'b1;
    idle(1, 1'b1);
    reset = 1'b0;
    idle(1, 1'b1);
    send(32'h0000007F, 32'h400, 1'b1, mk(32'h400, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 3'd7, 32'd0, 1'b1), 1'b1);
    send(32'h02940333, 32'h404, 1'b1, mk(32'h404, 7'h33, 5'd6, 5'd8, 5'd9, 3'd0, 7'h01, 3'd7, 32'd0, 1'b1), 1'b1);
    idle(3, 1'b1);
    chk("illegal_cnt_two", 64'(illegal_cnt), 64'd2);
    for (int i = 0; i < 300; i++) send({$urandom_range(0, 32'h1FFFFFF), 7'h7F}, 32'h500 + 32'(i * 4), 1'b0, '0, 1'b1);
    idle(3, 1'b1);
    chk("illegal_cnt_sat", 64'(illegal_cnt), 64'hFF);

    // Flush with the buffer full.
    send(32'h00100093, 32'h600, 1'b0, '0, 1'b0);
    send(32'h00200113, 32'h604, 1'b0, '0, 1'b0);
    step(1'b1, 32'h00300193, 32'h608, 1'b1, 1'b0, 1'b0, '0, acc);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of traffic.
    send(32'h00400213, 32'h700, 1'b0, '0, 1'b0);
    send(32'h00500293, 32'h704, 1'b0, '0, 1'b0);
    reset = 1'b1;
    step(1'b1, 32'h00600313, 32'h708, 1'b0, 1'b1, 1'b0, '0, acc);
    chk("reset_outputs_ctrl", 64'({out_valid, in_ready, opcode, rd, rs1, rs2, funct3, funct7,
                                   inst_type, illegal, decode_cnt, illegal_cnt}), 64'd0);
    chk("reset_outputs_data", {out_pc, imm}, 64'd0);
    reset = 1'b0;
    idle(1, 1'b0);
    chk("in_ready_after_midreset", 64'(in_ready), 64'd1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 9) < 7, gen_word(), $urandom & 32'hFFFFFFFC,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, 1'b0, '0, acc);
    end
    reset = 1'b0;
    idle(6, 1'b1);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
